// File: rtl/w0rm_bus_pkg.sv
// Shared types and helpers for the w0rm bus arbiter: FSM state encoding,
// timeout counter width and one-hot to index conversion.
package w0rm_bus_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2
    } bus_state_e;

    localparam int TMO_W = 16;

    // Index of the set bit in a one-hot vector of up to eight masters.
    function automatic logic [2:0] onehot_to_idx(input logic [7:0] oh);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (oh[i]) begin
                idx = i[2:0];
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/w0rm_rr_arbiter.sv
// Combinational round-robin pick: first requester strictly after last_grant_i,
// wrapping modulo N. The last-grant pointer is registered in the parent.
module w0rm_rr_arbiter
    import w0rm_bus_pkg::*;
#(
    parameter int N    = 2,
    parameter int IDXW = $clog2(N)
) (
    input  logic [N-1:0]    req_i,
    input  logic [IDXW-1:0] last_grant_i,
    output logic [N-1:0]    grant_o,
    output logic [IDXW-1:0] grant_idx_o
);

    // Scan the N positions following last_grant_i and keep the first requester.
    always_comb begin
        int  cand_int;
        logic [IDXW-1:0] cand;
        logic found;
        grant_o  = '0;
        found    = 1'b0;
        cand_int = 0;
        cand     = '0;
        for (int k = 1; k <= N; k++) begin
            cand_int = (int'(last_grant_i) + k) % N;
            cand     = cand_int[IDXW-1:0];
            if (!found && req_i[cand]) begin
                grant_o[cand] = 1'b1;
                found         = 1'b1;
            end else begin
                found = found;
            end
        end
    end

    assign grant_idx_o = IDXW'(onehot_to_idx(8'(grant_o)));

endmodule

// File: rtl/w0rm_bus_arbiter.sv
// N-master round-robin arbiter onto one external Address/Data/Read/Write/Valid bus.
// Optional slave timeout is compiled in with W0RM_BUS_TIMEOUT_EN.
module w0rm_bus_arbiter
    import w0rm_bus_pkg::*;
#(
    parameter int NUM_MASTERS    = 2,
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                              BaseCLK,
    input  logic                              Reset,
    input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_Address_i,
    input  logic [NUM_MASTERS*DATA_WIDTH-1:0] m_Data_i,
    input  logic [NUM_MASTERS-1:0]            m_Read_i,
    input  logic [NUM_MASTERS-1:0]            m_Write_i,
    input  logic [NUM_MASTERS-1:0]            m_Valid_i,
    output logic [DATA_WIDTH-1:0]             m_Data_o,
    output logic [NUM_MASTERS-1:0]            m_Valid_o,
    output logic [NUM_MASTERS-1:0]            m_Error_o,
    output logic [ADDR_WIDTH-1:0]             Address_o,
    output logic [DATA_WIDTH-1:0]             Data_o,
    output logic                              Read_o,
    output logic                              Write_o,
    output logic                              Valid_o,
    input  logic [DATA_WIDTH-1:0]             Data_i,
    input  logic                              Valid_i
);

    localparam int IDXW = $clog2(NUM_MASTERS);

    if (NUM_MASTERS < 2 || NUM_MASTERS > 8 || TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_cfg
        $error("w0rm_bus_arbiter: parameter out of range");
    end

    bus_state_e             state_q, state_d;
    logic [IDXW-1:0]        last_q, last_d;
    logic [NUM_MASTERS-1:0] grant_q, grant_d;
    logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
    logic [DATA_WIDTH-1:0]  wdata_q, wdata_d;
    logic                   read_q, read_d;
    logic                   write_q, write_d;
    logic                   valid_q, valid_d;
    logic [NUM_MASTERS-1:0] m_valid_q, m_valid_d;
    logic [DATA_WIDTH-1:0]  m_data_q, m_data_d;
    logic [NUM_MASTERS-1:0] gnt_oh_s;
    logic [IDXW-1:0]        gnt_idx_s;
`ifdef W0RM_BUS_TIMEOUT_EN
    logic [TMO_W-1:0]       cnt_q, cnt_d;
    logic [NUM_MASTERS-1:0] m_error_q, m_error_d;
`endif

    w0rm_rr_arbiter #(.N(NUM_MASTERS), .IDXW(IDXW)) u_rr (
        .req_i        (m_Valid_i),
        .last_grant_i (last_q),
        .grant_o      (gnt_oh_s),
        .grant_idx_o  (gnt_idx_s)
    );

    // Next-state and output-register logic for the IDLE/BUS/RESP sequence.
    always_comb begin
        state_d   = state_q;
        last_d    = last_q;
        grant_d   = grant_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        read_d    = read_q;
        write_d   = write_q;
        valid_d   = valid_q;
        m_valid_d = '0;
        m_data_d  = m_data_q;
`ifdef W0RM_BUS_TIMEOUT_EN
        cnt_d     = cnt_q;
        m_error_d = '0;
`endif
        case (state_q)
            IDLE: begin
                if (|m_Valid_i) begin
                    last_d  = gnt_idx_s;
                    grant_d = gnt_oh_s;
                    addr_d  = m_Address_i[gnt_idx_s*ADDR_WIDTH +: ADDR_WIDTH];
                    wdata_d = m_Data_i[gnt_idx_s*DATA_WIDTH +: DATA_WIDTH];
                    // Write wins when a master raises both strobes.
                    write_d = m_Write_i[gnt_idx_s];
                    read_d  = m_Read_i[gnt_idx_s] & ~m_Write_i[gnt_idx_s];
                    valid_d = 1'b1;
                    state_d = BUS;
`ifdef W0RM_BUS_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                end else begin
                    state_d = IDLE;
                end
            end
            BUS: begin
                if (Valid_i) begin
                    m_valid_d = grant_q;
                    m_data_d  = Data_i;
                    valid_d   = 1'b0;
                    state_d   = RESP;
                end
`ifdef W0RM_BUS_TIMEOUT_EN
                else if (cnt_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
                    m_valid_d = grant_q;
                    m_error_d = grant_q;
                    m_data_d  = '0;
                    valid_d   = 1'b0;
                    state_d   = RESP;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
`else
                else begin
                    state_d = BUS;
                end
`endif
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                valid_d = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge BaseCLK) begin
        if (Reset) begin
            state_q   <= IDLE;
            last_q    <= IDXW'(NUM_MASTERS - 1);
            grant_q   <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            read_q    <= 1'b0;
            write_q   <= 1'b0;
            valid_q   <= 1'b0;
            m_valid_q <= '0;
            m_data_q  <= '0;
`ifdef W0RM_BUS_TIMEOUT_EN
            cnt_q     <= '0;
            m_error_q <= '0;
`endif
        end else begin
            state_q   <= state_d;
            last_q    <= last_d;
            grant_q   <= grant_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            read_q    <= read_d;
            write_q   <= write_d;
            valid_q   <= valid_d;
            m_valid_q <= m_valid_d;
            m_data_q  <= m_data_d;
`ifdef W0RM_BUS_TIMEOUT_EN
            cnt_q     <= cnt_d;
            m_error_q <= m_error_d;
`endif
        end
    end

    assign Address_o = addr_q;
    assign Data_o    = wdata_q;
    assign Read_o    = read_q;
    assign Write_o   = write_q;
    assign Valid_o   = valid_q;
    assign m_Valid_o = m_valid_q;
    assign m_Data_o  = m_data_q;
`ifdef W0RM_BUS_TIMEOUT_EN
    assign m_Error_o = m_error_q;
`else
    assign m_Error_o = '0;
`endif

endmodule

// File: tb/tb_w0rm_bus_arbiter.sv
// Directed, table-driven bench for w0rm_bus_arbiter with three masters;
// timeout checks are included when W0RM_BUS_TIMEOUT_EN is defined.
module tb_w0rm_bus_arbiter;

    localparam int NM = 3;
    localparam int AW = 32;
    localparam int DW = 32;

    logic              clk;
    logic              rst;
    logic [NM*AW-1:0]  m_addr;
    logic [NM*DW-1:0]  m_wdata;
    logic [NM-1:0]     m_rd, m_wr, m_vld;
    logic [DW-1:0]     m_rdata;
    logic [NM-1:0]     m_rvld, m_err;
    logic [AW-1:0]     addr_o;
    logic [DW-1:0]     data_o;
    logic              rd_o, wr_o, vld_o;
    logic [DW-1:0]     s_data;
    logic              s_vld;

    int total = 0;
    int bad   = 0;

    w0rm_bus_arbiter #(
        .NUM_MASTERS(NM), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(4)
    ) dut (
        .BaseCLK(clk), .Reset(rst),
        .m_Address_i(m_addr), .m_Data_i(m_wdata),
        .m_Read_i(m_rd), .m_Write_i(m_wr), .m_Valid_i(m_vld),
        .m_Data_o(m_rdata), .m_Valid_o(m_rvld), .m_Error_o(m_err),
        .Address_o(addr_o), .Data_o(data_o), .Read_o(rd_o), .Write_o(wr_o),
        .Valid_o(vld_o), .Data_i(s_data), .Valid_i(s_vld)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] maddr(input int i);
        case (i)
            0:       return 32'h0000_1000;
            1:       return 32'h0000_0020;
            default: return 32'h0000_3300;
        endcase
    endfunction

    function automatic logic [31:0] mdata(input int i);
        case (i)
            0:       return 32'hAAAA_0000;
            1:       return 32'h1234_5678;
            default: return 32'h5555_0002;
        endcase
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic chk_all_zero(input string nm);
        chk({nm, "_ctl"}, {59'd0, vld_o, rd_o, wr_o, m_rvld != 3'b000, m_err != 3'b000}, 64'd0);
        chk({nm, "_addr"}, {32'd0, addr_o}, 64'd0);
        chk({nm, "_wdat"}, {32'd0, data_o}, 64'd0);
        chk({nm, "_rdat"}, {32'd0, m_rdata}, 64'd0);
    endtask

    // Advance negedges until Valid_o is seen, bounded.
    task automatic wait_vo(input string nm, output logic ok);
        ok = 1'b0;
        for (int i = 0; i < 10 && !ok; i++) begin
            @(negedge clk);
            if (vld_o) ok = 1'b1;
        end
        chk({nm, "_vo_seen"}, {63'd0, ok}, 64'd1);
    endtask

    task automatic run_txn(input string nm, input logic [2:0] req, input logic [2:0] rd,
                           input logic [2:0] wr, input int wc, input logic [31:0] sd,
                           input int gnt, input logic erd, input logic ewr);
        logic ok;
        m_vld = req; m_rd = rd; m_wr = wr;
        wait_vo(nm, ok);
        if (ok) begin
            chk({nm, "_addr"}, {32'd0, addr_o}, {32'd0, maddr(gnt)});
            chk({nm, "_wdat"}, {32'd0, data_o}, {32'd0, mdata(gnt)});
            chk({nm, "_rdwr"}, {62'd0, rd_o, wr_o}, {62'd0, erd, ewr});
            for (int w = 0; w < wc; w++) begin
                @(negedge clk);
                chk({nm, "_hold"}, {31'd0, vld_o, addr_o}, {31'd0, 1'b1, maddr(gnt)});
            end
            s_vld = 1'b1; s_data = sd;
            @(negedge clk);
            s_vld = 1'b0;
            chk({nm, "_pulse"}, {61'd0, m_rvld}, {61'd0, 3'(3'b001 << gnt)});
            chk({nm, "_rdat"}, {32'd0, m_rdata}, {32'd0, sd});
            chk({nm, "_err_vo"}, {60'd0, m_err, vld_o}, 64'd0);
        end
    endtask

    typedef struct {
        logic [2:0]  req, rd, wr;
        int          wc;
        logic [31:0] sd;
        int          gnt;
        logic        erd, ewr;
    } vec_t;

    vec_t vecs[10];

    initial begin
        logic ok;
        int   npulse, last_t, expg, hi;

        vecs[0] = '{3'b001, 3'b001, 3'b000, 2, 32'hDEAD_BEEF, 0, 1'b1, 1'b0};
        vecs[1] = '{3'b010, 3'b010, 3'b010, 0, 32'h0000_0011, 1, 1'b0, 1'b1};
        vecs[2] = '{3'b111, 3'b111, 3'b000, 1, 32'hA5A5_0001, 2, 1'b1, 1'b0};
        vecs[3] = '{3'b111, 3'b111, 3'b000, 0, 32'hA5A5_0002, 0, 1'b1, 1'b0};
        vecs[4] = '{3'b101, 3'b101, 3'b000, 0, 32'hA5A5_0003, 2, 1'b1, 1'b0};
        vecs[5] = '{3'b110, 3'b110, 3'b000, 1, 32'hA5A5_0004, 1, 1'b1, 1'b0};
        vecs[6] = '{3'b110, 3'b000, 3'b110, 0, 32'hA5A5_0005, 2, 1'b0, 1'b1};
        vecs[7] = '{3'b100, 3'b000, 3'b100, 2, 32'hA5A5_0006, 2, 1'b0, 1'b1};
        vecs[8] = '{3'b011, 3'b011, 3'b000, 0, 32'hA5A5_0007, 0, 1'b1, 1'b0};
        vecs[9] = '{3'b011, 3'b011, 3'b000, 1, 32'hA5A5_0008, 1, 1'b1, 1'b0};

        rst = 1'b1; m_vld = '0; m_rd = '0; m_wr = '0; s_vld = 1'b0; s_data = '0;
        for (int i = 0; i < NM; i++) begin
            m_addr[i*AW +: AW]  = maddr(i);
            m_wdata[i*DW +: DW] = mdata(i);
        end
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        rst = 1'b0;

        for (int v = 0; v < 10; v++) begin
            run_txn($sformatf("vec%0d", v), vecs[v].req, vecs[v].rd, vecs[v].wr,
                    vecs[v].wc, vecs[v].sd, vecs[v].gnt, vecs[v].erd, vecs[v].ewr);
        end

        // Continuous requests from masters 0 and 1 with a zero-wait slave.
        m_vld = 3'b011; m_rd = 3'b011; m_wr = 3'b000;
        s_vld = 1'b1; s_data = 32'hC0DE_0000;
        npulse = 0; last_t = 0; expg = 0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (m_rvld != 3'b000) begin
                chk("alt_gnt", {61'd0, m_rvld}, {61'd0, 3'(3'b001 << expg)});
                chk("alt_rdat", {32'd0, m_rdata}, {32'd0, 32'hC0DE_0000});
                if (npulse > 0) chk("alt_gap", 64'(k - last_t), 64'd3);
                last_t = k;
                expg   = 1 - expg;
                npulse++;
            end
        end
        chk("alt_count", 64'(npulse), 64'd4);
        s_vld = 1'b0; m_vld = '0;

        // Request withdrawn mid-access still gets its response.
        m_vld = 3'b010; m_rd = 3'b000; m_wr = 3'b010;
        wait_vo("drop", ok);
        chk("drop_addr", {32'd0, addr_o}, {32'd0, maddr(1)});
        m_vld = '0;
        repeat (2) @(negedge clk);
        s_vld = 1'b1; s_data = 32'h0BAD_F00D;
        @(negedge clk);
        s_vld = 1'b0;
        chk("drop_pulse", {61'd0, m_rvld}, {61'd0, 3'b010});

        // Reset during BUS, then a late slave acknowledge.
        m_vld = 3'b001; m_rd = 3'b001; m_wr = 3'b000;
        wait_vo("rstbus", ok);
        rst = 1'b1;
        @(negedge clk);
        chk_all_zero("rst_mid");
        rst = 1'b0; m_vld = '0; s_vld = 1'b1; s_data = 32'hFFFF_FFFF;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("late_ack", {60'd0, m_rvld, vld_o}, 64'd0);
        end
        s_vld = 1'b0;
        run_txn("post_rst", 3'b111, 3'b111, 3'b000, 0, 32'h7777_0000, 0, 1'b1, 1'b0);

`ifdef W0RM_BUS_TIMEOUT_EN
        m_vld = 3'b001; m_rd = 3'b001; m_wr = 3'b000;
        wait_vo("tmo", ok);
        hi = 1;
        for (int k = 0; k < 20 && vld_o; k++) begin
            @(negedge clk);
            if (vld_o) hi++;
        end
        chk("tmo_len", 64'(hi), 64'd4);
        chk("tmo_pulse", {61'd0, m_rvld}, {61'd0, 3'b001});
        chk("tmo_err", {61'd0, m_err}, {61'd0, 3'b001});
        chk("tmo_rdat", {32'd0, m_rdata}, 64'd0);
        run_txn("tmo_edge", 3'b001, 3'b001, 3'b000, 3, 32'h600D_0001, 0, 1'b1, 1'b0);
`else
        hi = 0;
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
